fetch_queue_unit: RTL
=====================

Name: fetch_queue_unit

Overview:
- Instruction-fetch stage directly downstream of the PC register; consumes `pc` and computes `new_pc`, which feeds back into the PC register.
- Issues in-order word reads to instruction memory over a valid/ready request channel; the memory responds in order with variable latency.
- Buffers fetched instructions, each tagged with its PC, and presents them to decode over a valid/ready channel.
- Handles control-flow redirects by flushing buffered entries and discarding stale in-flight responses.

Parameters:
- DEPTH, 4, number of queue slots (power of two, at least 2); bounds entries in flight plus entries buffered.
- PTR_W, $clog2(DEPTH), slot pointer width (derived).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- pc  in  32  current PC from the PC register.
- new_pc  out  32  next PC to the PC register (combinational).
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  32  fetch address; always equals `pc`.
- imem_req_ready  in  1  memory accepts the request.
- imem_rsp_valid  in  1  response data valid; responses return in request order.
- imem_rsp_data  in  32  instruction word.
- redirect_valid  in  1  branch/jump taken; flush request.
- redirect_pc  in  32  redirect target.
- out_valid  out  1  instruction available to decode.
- out_instr  out  32  instruction word.
- out_pc  out  32  PC of `out_instr`.
- out_ready  in  1  decode accepts.

Behaviour:
- Slots are allocated at request issue, filled at response and freed at decode handshake. Each slot holds pc[31:0], instr[31:0] and a filled bit.
- Three pointers (`alloc`, `fill`, `rd`), each PTR_W+1 bits wide with a wrap bit. `used = alloc - rd`.
- `imem_req_valid = (used < DEPTH) && !redirect_valid && (discard_cnt == 0)`.
- Issue fire (valid && ready): write `pc` into slot[`alloc`], clear its filled bit, advance `alloc`.
- `new_pc`:
  - `redirect_valid`: `redirect_pc`.
  - Otherwise on issue fire: `pc + 32'd4` (wraps modulo 2^32).
  - Otherwise: `pc`.
- Response with `discard_cnt == 0`: write data into slot[`fill`], set filled, advance `fill`.
- Response with `discard_cnt > 0`: drop the data; `discard_cnt` decrements.
- `out_valid = (rd != fill)`. `out_instr` and `out_pc` come from slot[`rd`]. Handshake advances `rd`.
- Latency: a response arriving in cycle N is visible at the output in cycle N+1 (registered slot). No bypass.
- Redirect in cycle N:
  - All three pointers reset to 0 at edge N.
  - `discard_cnt` loads (`alloc - fill`) minus 1 if an undiscarded response is accepted in the same cycle.
  - No request is issued in cycle N.
  - An out handshake in cycle N is still consumed by decode.
  - A redirect while `discard_cnt > 0` adds the new outstanding count, although no issues can have occurred in between.
- Full (`used == DEPTH`): `imem_req_valid` low; `new_pc = pc`.
- Empty: `out_valid` low.
- Simultaneous response, handshake and issue in one cycle are all legal and independent.
- Reset (asynchronous, active-low): pointers 0, `discard_cnt` 0, all filled bits 0, `out_valid` 0, `imem_req_valid` 0 while reset is asserted. `new_pc` passes `pc` through. Reset mid-transaction abandons any outstanding responses; the memory is reset alongside this block.
- A response arriving with no outstanding request is a protocol error. In simulation it triggers an assertion; the RTL ignores it.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined: adds outputs `perf_issued[31:0]`, `perf_flushed[31:0]` and `perf_full_stall[31:0]`. They count issue fires, discarded responses plus slots dropped at redirect, and cycles with `used == DEPTH`. All reset to 0 and saturate at all-ones.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package `kgp_fetch_pkg`: ADDR_W=32, INSTR_W=32, PC_STEP=32'd4, and typedef `fetch_slot_t` {pc, instr, filled}.
- One sub-module, `fetch_slot_ram`: DEPTH×64 register array with separate alloc-write, fill-write and read ports. Pointer and discard control stay in the top level.

Test Plan:
- Reset, then `pc=0`, `req_ready=1`, 1-cycle response latency, `out_ready=1` → requests at 0,4,8…; `out_pc`/`out_instr` stream in order, first output 2 cycles after first issue.
- `out_ready=0` with DEPTH=4 → exactly 4 issues, then `imem_req_valid=0` and `new_pc` holds at 16; releasing `out_ready` drains 0,4,8,12 and resumes issue.
- 3 requests outstanding, redirect to 0x100 → `out_valid` drops, 3 responses discarded, next request addr 0x100, first output `out_pc=0x100`.
- Redirect in the same cycle as an undiscarded response → `discard_cnt` equals outstanding−1; no stale instruction is presented.
- `pc=0xFFFFFFFC` issue → `new_pc=0x00000000`.
- Async reset asserted mid-burst, between clock edges → `out_valid` and `imem_req_valid` go to 0 immediately; after release, fetch restarts cleanly from the PC register value.

Source files
------------

// File: rtl/kgp_fetch_pkg.sv
// Shared types and constants for the instruction-fetch queue.
// Also holds the saturating-add helper used by the FETCH_PERF_EN counters.
package kgp_fetch_pkg;

    localparam int          ADDR_W  = 32;
    localparam int          INSTR_W = 32;
    localparam logic [31:0] PC_STEP = 32'd4;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
        logic               filled;
    } fetch_slot_t;

    function automatic logic [ADDR_W-1:0] next_seq_pc(input logic [ADDR_W-1:0] cur_pc);
        return cur_pc + PC_STEP;
    endfunction

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/fetch_slot_ram.sv
// Fetch slot storage: DEPTH entries of {pc, instr} plus a per-slot filled flag.
// Separate write ports for request allocation and response fill; asynchronous read of slot[rd].
module fetch_slot_ram
    import kgp_fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               alloc_en_i,
    input  logic [PTR_W-1:0]   alloc_idx_i,
    input  logic [ADDR_W-1:0]  alloc_pc_i,
    input  logic               fill_en_i,
    input  logic [PTR_W-1:0]   fill_idx_i,
    input  logic [INSTR_W-1:0] fill_instr_i,
    input  logic [PTR_W-1:0]   rd_idx_i,
    output fetch_slot_t        rd_slot_o
);

    logic [ADDR_W-1:0]  pc_mem    [DEPTH];
    logic [INSTR_W-1:0] instr_mem [DEPTH];
    logic [DEPTH-1:0]   filled_q;

    always_ff @(posedge clk) begin
        if (alloc_en_i) begin
            pc_mem[alloc_idx_i] <= alloc_pc_i;
        end
        if (fill_en_i) begin
            instr_mem[fill_idx_i] <= fill_instr_i;
        end
    end

    // Alloc and fill never target the same slot in one cycle: that would need a full queue.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_filled
            logic filled_bit_q;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    filled_bit_q <= 1'b0;
                end else if (alloc_en_i && (alloc_idx_i == PTR_W'(gi))) begin
                    filled_bit_q <= 1'b0;
                end else if (fill_en_i && (fill_idx_i == PTR_W'(gi))) begin
                    filled_bit_q <= 1'b1;
                end
            end
            assign filled_q[gi] = filled_bit_q;
        end
    endgenerate

    assign rd_slot_o.pc     = pc_mem[rd_idx_i];
    assign rd_slot_o.instr  = instr_mem[rd_idx_i];
    assign rd_slot_o.filled = filled_q[rd_idx_i];

endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction fetch queue: issues in-order imem reads, buffers PC-tagged words, flushes on redirect.
// Define FETCH_PERF_EN to add the perf_issued / perf_flushed / perf_full_stall counters.
module fetch_queue_unit
    import kgp_fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  pc,
    output logic [ADDR_W-1:0]  new_pc,
    output logic               imem_req_valid,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_req_ready,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               out_valid,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
`ifdef FETCH_PERF_EN
    output logic [31:0]        perf_issued,
    output logic [31:0]        perf_flushed,
    output logic [31:0]        perf_full_stall,
`endif
    input  logic               out_ready
);

    localparam logic [PTR_W:0] DEPTH_P = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] ONE_P   = (PTR_W+1)'(1);
    localparam logic [PTR_W:0] ZERO_P  = '0;

    logic [PTR_W:0] alloc_q, alloc_d;
    logic [PTR_W:0] fill_q, fill_d;
    logic [PTR_W:0] rd_q, rd_d;
    logic [PTR_W:0] discard_cnt_q, discard_cnt_d;

    logic [PTR_W:0] used;
    logic [PTR_W:0] outstanding;
    logic           full;
    logic           issue_fire;
    logic           rsp_accept;
    logic           rsp_drop;
    logic           out_fire;
    fetch_slot_t    rd_slot;

    assign used        = alloc_q - rd_q;
    assign outstanding = alloc_q - fill_q;
    assign full        = (used == DEPTH_P);

    // Gated by rst so nothing is requested while the block is held in reset.
    assign imem_req_valid = rst && !full && !redirect_valid && (discard_cnt_q == ZERO_P);
    assign imem_req_addr  = pc;
    assign issue_fire     = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is a protocol error and is simply ignored.
    assign rsp_accept = imem_rsp_valid && (discard_cnt_q == ZERO_P) && (outstanding != ZERO_P);
    assign rsp_drop   = imem_rsp_valid && (discard_cnt_q != ZERO_P);

    assign out_valid = (rd_q != fill_q) && rd_slot.filled;
    assign out_instr = rd_slot.instr;
    assign out_pc    = rd_slot.pc;
    assign out_fire  = out_valid && out_ready;

    always_comb begin
        new_pc = pc;
        if (rst) begin
            if (redirect_valid) begin
                new_pc = redirect_pc;
            end else if (issue_fire) begin
                new_pc = next_seq_pc(pc);
            end
        end
    end

    always_comb begin
        alloc_d       = alloc_q;
        fill_d        = fill_q;
        rd_d          = rd_q;
        discard_cnt_d = discard_cnt_q;
        if (redirect_valid) begin
            alloc_d = ZERO_P;
            fill_d  = ZERO_P;
            rd_d    = ZERO_P;
            // Everything still in flight is stale; a response accepted this cycle is already home.
            discard_cnt_d = discard_cnt_q - (rsp_drop ? ONE_P : ZERO_P)
                          + outstanding - (rsp_accept ? ONE_P : ZERO_P);
        end else begin
            if (issue_fire) begin
                alloc_d = alloc_q + ONE_P;
            end
            if (rsp_accept) begin
                fill_d = fill_q + ONE_P;
            end
            if (out_fire) begin
                rd_d = rd_q + ONE_P;
            end
            if (rsp_drop) begin
                discard_cnt_d = discard_cnt_q - ONE_P;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alloc_q       <= ZERO_P;
            fill_q        <= ZERO_P;
            rd_q          <= ZERO_P;
            discard_cnt_q <= ZERO_P;
        end else begin
            alloc_q       <= alloc_d;
            fill_q        <= fill_d;
            rd_q          <= rd_d;
            discard_cnt_q <= discard_cnt_d;
        end
    end

    fetch_slot_ram #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_slot_ram (
        .clk          (clk),
        .rst          (rst),
        .alloc_en_i   (issue_fire),
        .alloc_idx_i  (alloc_q[PTR_W-1:0]),
        .alloc_pc_i   (pc),
        .fill_en_i    (rsp_accept),
        .fill_idx_i   (fill_q[PTR_W-1:0]),
        .fill_instr_i (imem_rsp_data),
        .rd_idx_i     (rd_q[PTR_W-1:0]),
        .rd_slot_o    (rd_slot)
    );

    assert property (@(posedge clk) disable iff (!rst)
        imem_rsp_valid |-> ((discard_cnt_q != ZERO_P) || (fill_q != alloc_q)));

`ifdef FETCH_PERF_EN
    logic [31:0]    perf_issued_q, perf_issued_d;
    logic [31:0]    perf_flushed_q, perf_flushed_d;
    logic [31:0]    perf_full_stall_q, perf_full_stall_d;
    logic [PTR_W:0] buf_drop;

    // Buffered words thrown away by a redirect; in-flight ones are counted as they are discarded.
    always_comb begin
        buf_drop = (fill_q - rd_q) + (rsp_accept ? ONE_P : ZERO_P) - (out_fire ? ONE_P : ZERO_P);
        perf_issued_d     = sat_add32(perf_issued_q, {31'd0, issue_fire});
        perf_full_stall_d = sat_add32(perf_full_stall_q, {31'd0, full});
        perf_flushed_d    = sat_add32(perf_flushed_q, {31'd0, rsp_drop});
        if (redirect_valid) begin
            perf_flushed_d = sat_add32(perf_flushed_d, {{(31-PTR_W){1'b0}}, buf_drop});
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_issued_q     <= 32'd0;
            perf_flushed_q    <= 32'd0;
            perf_full_stall_q <= 32'd0;
        end else begin
            perf_issued_q     <= perf_issued_d;
            perf_flushed_q    <= perf_flushed_d;
            perf_full_stall_q <= perf_full_stall_d;
        end
    end

    assign perf_issued     = perf_issued_q;
    assign perf_flushed    = perf_flushed_q;
    assign perf_full_stall = perf_full_stall_q;
`endif

endmodule
